// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: frame FSM states,
// scan-code prefix bytes and the frame-level parity/stop check.
package ps2_key_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    // Bits sampled after the start bit: 8 data, parity, stop.
    localparam int unsigned PS2_FRAME_BITS = 10;

    // frame[7:0] data, frame[8] parity, frame[9] stop; odd parity over data+parity.
    function automatic logic ps2_frame_good(input logic [PS2_FRAME_BITS-1:0] frame);
        return (^frame[8:0]) & frame[9];
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte channel from the frame receiver to the prefix decoder: one-cycle
// byte_ok / byte_err pulses qualifying the received byte.
interface ps2_key_decoder_if;
    logic [7:0] data;
    logic       byte_ok;
    logic       byte_err;

    modport master (output data, output byte_ok, output byte_err);
    modport slave  (input  data, input  byte_ok, input  byte_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw bus, detects falling clock edges,
// shifts in an 11-bit frame and reports a good byte or a parity/stop/timeout error.
module ps2_frame_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ps2_clk,
    input  logic                      ps2_dat,
    ps2_key_decoder_if.master         byte_if
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;

    rx_state_e                 state_q, state_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      byte_ok, byte_err;

    // Synchronizers reset high so a reset never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        byte_ok   = 1'b0;
        byte_err  = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                tmo_d     = '0;
                if (fall && !dat_sync_q) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_d   = {dat_sync_q, shift_q[PS2_FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_d     = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    byte_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                if (ps2_frame_good(shift_q)) begin
                    byte_ok = 1'b1;
                end else begin
                    byte_err = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
        end
    end

    assign byte_if.data     = shift_q[7:0];
    assign byte_if.byte_ok  = byte_ok;
    assign byte_if.byte_err = byte_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard scan-code decoder: folds E0/F0 prefixes into ext/break flags
// and emits one registered key_valid per complete key code.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid,
    output logic       rx_err
);

    ps2_key_decoder_if byte_if ();

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk     (CLOCK_50),
        .rst_n   (Resetn),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .byte_if (byte_if)
    );

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_break_q, key_break_d;
    logic       key_ext_q, key_ext_d;
    logic       key_valid_q, key_valid_d;
    logic       rx_err_q, rx_err_d;

    // byte_ok and byte_err are exclusive, so key_valid and rx_err are too.
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_code_d  = key_code_q;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        key_valid_d = 1'b0;
        rx_err_d    = 1'b0;
        if (byte_if.byte_err) begin
            rx_err_d = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
        end else if (byte_if.byte_ok) begin
            if (byte_if.data == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_if.data == PS2_PREFIX_BREAK) begin
                brk_d = 1'b1;
            end else begin
                key_code_d  = byte_if.data;
                key_break_d = brk_q;
                key_ext_d   = ext_q;
                key_valid_d = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_code_q  <= '0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            key_valid_q <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_code_q  <= key_code_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
            key_valid_q <= key_valid_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_break = key_break_q;
    assign key_ext   = key_ext_q;
    assign key_valid = key_valid_q;
    assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of byte sequences with expected
// key events, plus hand-written timeout and mid-frame reset sequences.
module tb_ps2_key_decoder;

    localparam int unsigned TMO  = 200;
    localparam int          HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_valid;
    logic       rx_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .rx_err    (rx_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int fails  = 0;

    // Event monitor: counts pulses and latches the event fields.
    int         valid_cnt   = 0;
    int         err_cnt     = 0;
    int         overlap_cnt = 0;
    logic [7:0] cap_code    = '0;
    logic       cap_brk     = 1'b0;
    logic       cap_ext     = 1'b0;

    always @(negedge CLOCK_50) begin
        if (key_valid) begin
            valid_cnt++;
            cap_code = key_code;
            cap_brk  = key_break;
            cap_ext  = key_ext;
        end
        if (rx_err) err_cnt++;
        if (key_valid && rx_err) overlap_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(posedge CLOCK_50);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge CLOCK_50);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic flip);
        logic par;
        par = (~^d) ^ flip;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (2 * HALF) @(posedge CLOCK_50);
    endtask

    typedef struct {
        int             n;
        logic [2:0][7:0] bytes;
        logic [2:0]     flip;
        int             exp_valid;
        int             exp_err;
        logic [7:0]     code;
        logic           brk;
        logic           ext;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [2:0] flip,
                                input int ev, input int ee, input logic [7:0] code,
                                input logic brk, input logic ext);
        vec_t v;
        v.n = n; v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = b2; v.flip = flip;
        v.exp_valid = ev; v.exp_err = ee; v.code = code; v.brk = brk; v.ext = ext;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        int v0, e0;
        // Expected outputs are the held port values after each sequence.
        vecs[0] = mk(1, 8'h1C, 8'h00, 8'h00, 3'b000, 1, 0, 8'h1C, 1'b0, 1'b0);
        vecs[1] = mk(2, 8'hF0, 8'h1C, 8'h00, 3'b000, 1, 0, 8'h1C, 1'b1, 1'b0);
        vecs[2] = mk(3, 8'hE0, 8'hF0, 8'h75, 3'b000, 1, 0, 8'h75, 1'b1, 1'b1);
        vecs[3] = mk(1, 8'h1C, 8'h00, 8'h00, 3'b000, 1, 0, 8'h1C, 1'b0, 1'b0);
        vecs[4] = mk(1, 8'h1C, 8'h00, 8'h00, 3'b001, 0, 1, 8'h1C, 1'b0, 1'b0);
        vecs[5] = mk(2, 8'hF0, 8'h1C, 8'h00, 3'b000, 1, 0, 8'h1C, 1'b1, 1'b0);
        vecs[6] = mk(2, 8'hE0, 8'h6B, 8'h00, 3'b000, 1, 0, 8'h6B, 1'b0, 1'b1);
        vecs[7] = mk(3, 8'hE0, 8'h12, 8'h1C, 3'b010, 1, 1, 8'h1C, 1'b0, 1'b0);

        Resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_outputs", {key_code, key_break, key_ext, key_valid, rx_err}, '0);
        Resetn = 1'b1;
        repeat (10) @(posedge CLOCK_50);

        for (int k = 0; k < 8; k++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            for (int j = 0; j < vecs[k].n; j++) send_byte(vecs[k].bytes[j], vecs[k].flip[j]);
            repeat (50) @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            chk($sformatf("vec%0d_valid_cnt", k), valid_cnt - v0, vecs[k].exp_valid);
            chk($sformatf("vec%0d_err_cnt", k), err_cnt - e0, vecs[k].exp_err);
            chk($sformatf("vec%0d_key_code", k), key_code, vecs[k].code);
            chk($sformatf("vec%0d_key_break", k), key_break, vecs[k].brk);
            chk($sformatf("vec%0d_key_ext", k), key_ext, vecs[k].ext);
        end
        chk("captured_code_at_pulse", {cap_code, cap_brk, cap_ext}, {8'h1C, 1'b0, 1'b0});

        // Timeout: start bit plus 4 data bits, then the bus goes quiet.
        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (TMO + 10) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("timeout_err_cnt", err_cnt - e0, 1);
        chk("timeout_valid_cnt", valid_cnt - v0, 0);
        send_byte(8'h29, 1'b0);
        repeat (50) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("after_timeout_valid_cnt", valid_cnt - v0, 1);
        chk("after_timeout_err_cnt", err_cnt - e0, 1);
        chk("after_timeout_code", {key_code, key_break, key_ext}, {8'h29, 1'b0, 1'b0});

        // Reset in the middle of a frame discards the partial frame.
        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        #3 Resetn = 1'b0;
        #3;
        chk("midreset_async_outputs", {key_code, key_break, key_ext, key_valid, rx_err}, '0);
        repeat (3) @(negedge CLOCK_50);
        chk("midreset_outputs", {key_code, key_break, key_ext, key_valid, rx_err}, '0);
        ps2_dat = 1'b1;
        ps2_clk = 1'b1;
        @(posedge CLOCK_50);
        Resetn = 1'b1;
        repeat (10) @(posedge CLOCK_50);
        send_byte(8'h1C, 1'b0);
        repeat (50) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("after_reset_valid_cnt", valid_cnt - v0, 1);
        chk("after_reset_err_cnt", err_cnt - e0, 0);
        chk("after_reset_code", {key_code, key_break, key_ext}, {8'h1C, 1'b0, 1'b0});

        chk("valid_err_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
